// File: rtl/ece581_lp_pkg.sv
// Shared types and constants for the ECE-581 LP power-management sequencer.
// Sequencer states, default phase lengths, domain indices and a small sizing helper.
package ece581_lp_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StIso,
    StSave,
    StWaitOff,
    StWaitOn,
    StRst,
    StRestore,
    StDone,
    StErr
  } pmu_state_t;

  localparam int unsigned ISO_SETUP_DEF = 2;
  localparam int unsigned RST_HOLD_DEF  = 2;
  localparam int unsigned TIMEOUT_DEF   = 15;

  localparam int unsigned DOM_A = 0;
  localparam int unsigned DOM_B = 1;
  localparam int unsigned DOM_C = 2;
  localparam int unsigned DOM_D = 3;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ece581_pmu_timer.sv
// Loadable up-counter shared by the isolation-setup, reset-hold and ack-timeout phases.
// start_i clears the count and latches the terminal value; term_o flags count == limit.
module ece581_pmu_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             inc_i,
  input  logic [Width-1:0] limit_i,
  output logic             term_o
);

  logic [Width-1:0] count_q;
  logic [Width-1:0] limit_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      limit_q <= '0;
    end else if (start_i) begin
      count_q <= '0;
      limit_q <= limit_i;
    end else if (inc_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign term_o = (count_q == limit_q);

endmodule

// File: rtl/ece581_pmu_seq.sv
// Power-management sequencer: steps one domain at a time through isolation, retention,
// power-switch control and domain reset, closing the loop on the switch acknowledge.
module ece581_pmu_seq
  import ece581_lp_pkg::*;
#(
  parameter int unsigned NUM_DOM   = 4,
  parameter int unsigned ISO_SETUP = ISO_SETUP_DEF,
  parameter int unsigned RST_HOLD  = RST_HOLD_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                       upf_clk_i,
  input  logic                       soc_reset_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [$clog2(NUM_DOM)-1:0] req_dom_i,
  input  logic                       req_on_i,
  input  logic [NUM_DOM-1:0]         sw_ack_i,
  output logic [NUM_DOM-1:0]         en_o,
  output logic [NUM_DOM-1:0]         iso_en_o,
  output logic [NUM_DOM-1:0]         ret_save_o,
  output logic [NUM_DOM-1:0]         ret_restore_o,
  output logic [NUM_DOM-1:0]         dom_rst_o,
  output logic [NUM_DOM-1:0]         pwr_status_o,
  output logic                       done_o,
  output logic                       err_o
);

  localparam int unsigned DW = $clog2(NUM_DOM);
  localparam int unsigned TW = $clog2(max3(ISO_SETUP, RST_HOLD, TIMEOUT) + 1);
  // Phase lengths count from zero, so hold phases terminate one below their length.
  localparam logic [TW-1:0] IsoLim  = TW'(ISO_SETUP - 1);
  localparam logic [TW-1:0] RstLim  = TW'(RST_HOLD - 1);
  localparam logic [TW-1:0] WaitLim = TW'(TIMEOUT);

  pmu_state_t state_q;
  logic [DW-1:0]      dom_q;
  logic [NUM_DOM-1:0] en_q, iso_q, save_q, restore_q, rst_q, pwr_q;
  logic               ready_q, done_q, err_q;

  logic          xfer, bad_dom, noop, ack;
  logic          tmr_start, tmr_inc, tmr_term;
  logic [TW-1:0] tmr_limit;

  assign xfer    = req_valid_i && ready_q;
  assign bad_dom = ({1'b0, req_dom_i} >= (DW + 1)'(NUM_DOM));
  assign noop    = (req_on_i == pwr_q[req_dom_i]);
  assign ack     = sw_ack_i[dom_q];

  always_comb begin
    tmr_start = 1'b0;
    tmr_limit = WaitLim;
    unique case (state_q)
      StIdle: begin
        tmr_start = xfer;
        if (!req_on_i) tmr_limit = IsoLim;
      end
      StSave:   tmr_start = 1'b1;
      StWaitOn: begin
        if (ack) begin
          tmr_start = 1'b1;
          tmr_limit = RstLim;
        end
      end
      default: ;
    endcase
  end

  assign tmr_inc = (state_q inside {StIso, StWaitOff, StWaitOn, StRst});

  ece581_pmu_timer #(
    .Width(TW)
  ) u_timer (
    .clk_i  (upf_clk_i),
    .rst_i  (soc_reset_i),
    .start_i(tmr_start),
    .inc_i  (tmr_inc),
    .limit_i(tmr_limit),
    .term_o (tmr_term)
  );

  always_ff @(posedge upf_clk_i) begin
    if (soc_reset_i) begin
      state_q   <= StIdle;
      dom_q     <= '0;
      en_q      <= '1;
      pwr_q     <= '1;
      iso_q     <= '0;
      save_q    <= '0;
      restore_q <= '0;
      rst_q     <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      save_q    <= '0;
      restore_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (xfer) begin
            ready_q <= 1'b0;
            dom_q   <= req_dom_i;
            if (bad_dom) begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end else if (noop) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else if (!req_on_i) begin
              state_q             <= StIso;
              iso_q[req_dom_i]    <= 1'b1;
            end else begin
              state_q             <= StWaitOn;
              en_q[req_dom_i]     <= 1'b1;
            end
          end
        end
        StIso: begin
          if (tmr_term) begin
            state_q       <= StSave;
            save_q[dom_q] <= 1'b1;
          end
        end
        StSave: begin
          state_q      <= StWaitOff;
          en_q[dom_q]  <= 1'b0;
          pwr_q[dom_q] <= 1'b0;
          rst_q[dom_q] <= 1'b1;
        end
        StWaitOff: begin
          if (!ack) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else if (tmr_term) begin
            state_q <= StErr;
            err_q   <= 1'b1;
          end
        end
        StWaitOn: begin
          if (ack) begin
            state_q <= StRst;
          end else if (tmr_term) begin
            state_q      <= StErr;
            err_q        <= 1'b1;
            en_q[dom_q]  <= 1'b0;
            pwr_q[dom_q] <= 1'b0;
          end
        end
        StRst: begin
          if (tmr_term) begin
            state_q          <= StRestore;
            rst_q[dom_q]     <= 1'b0;
            restore_q[dom_q] <= 1'b1;
          end
        end
        StRestore: begin
          state_q      <= StDone;
          done_q       <= 1'b1;
          iso_q[dom_q] <= 1'b0;
          pwr_q[dom_q] <= 1'b1;
        end
        StDone, StErr: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o   = ready_q;
  assign en_o          = en_q;
  assign iso_en_o      = iso_q;
  assign ret_save_o    = save_q;
  assign ret_restore_o = restore_q;
  assign dom_rst_o     = rst_q;
  assign pwr_status_o  = pwr_q;
  assign done_o        = done_q;
  assign err_o         = err_q;

endmodule
